// File: rtl/pipe_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_skid_buffer: two-entry skid buffer that fully registers a valid/ready |
// | handshake between pipeline stages. Optional macro: PIPE_SKID_STALL_CNT_EN. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_skid_buffer #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [DW-1:0] s_data_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [DW-1:0] m_data_o,
    output logic [CW-1:0] stall_cnt_o
);

    // State is the pair {main_v, skid_v}; 2'b01 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          main_v_q, main_v_d;
    logic          skid_v_q, skid_v_d;
    logic          s_ready_q, s_ready_d;
    logic          s_fire;
    logic          m_fire;

    assign s_fire = s_valid_i & s_ready_q;
    assign m_fire = main_v_q & m_ready_i;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            case ({main_v_q, skid_v_q})
                ST_EMPTY: begin
                    if (s_fire) begin
                        main_d   = s_data_i;
                        main_v_d = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (s_fire && m_fire) begin
                        main_d = s_data_i;
                    end else if (s_fire) begin
                        skid_d   = s_data_i;
                        skid_v_d = 1'b1;
                    end else if (m_fire) begin
                        main_v_d = 1'b0;
                    end
                end
                ST_FULL: begin
                    if (m_fire) begin
                        main_d   = skid_q;
                        skid_v_d = 1'b0;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
        // Ready is precomputed from next-state so it leaves straight from a flop.
        s_ready_d = ~skid_v_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q    <= '0;
            skid_q    <= '0;
            main_v_q  <= 1'b0;
            skid_v_q  <= 1'b0;
            s_ready_q <= 1'b1;
        end else begin
            main_q    <= main_d;
            skid_q    <= skid_d;
            main_v_q  <= main_v_d;
            skid_v_q  <= skid_v_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = main_v_q;
    assign m_data_o  = main_q;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            stall_cnt_d = '0;
        end else if (main_v_q && !m_ready_i && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = {CW{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_buffer.sv
`default_nettype none
// Self-checking bench for pipe_skid_buffer: vector table, corner sequences and a
// randomized run, all scored against a queue model of the two-entry buffer.
module tb_pipe_skid_buffer;

    localparam int DW = 32;
    localparam int CW = 4;
`ifdef PIPE_SKID_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic [DW-1:0] s_data_i;
    logic          m_valid_o;
    logic          m_ready_i;
    logic [DW-1:0] m_data_o;
    logic [CW-1:0] stall_cnt_o;

    pipe_skid_buffer #(.DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .s_data_i   (s_data_i),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_data_o   (m_data_o),
        .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int delivered = 0;

    // Reference model: the queue holds accepted, not yet delivered beats in order.
    logic [DW-1:0] mq[$];
    int            mcnt = 0;

    typedef struct {
        logic          sv;
        logic [DW-1:0] sd;
        logic          mr;
        logic          exp_rdy;
        logic          exp_val;
        logic [DW-1:0] exp_dat;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drive, check current outputs against model, clock, update model.
    task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic fl);
        int  pre_size;
        logic s_fire;
        s_valid_i = sv;
        s_data_i  = sd;
        m_ready_i = mr;
        flush_i   = fl;
        #1;
        pre_size = mq.size();
        chk("s_ready", 64'(s_ready_o), 64'(pre_size < 2));
        chk("m_valid", 64'(m_valid_o), 64'(pre_size > 0));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(mcnt));
        if (pre_size > 0) chk("m_data", 64'(m_data_o), 64'(mq[0]));
        s_fire = sv && (pre_size < 2);
        @(posedge clk);
        #1;
        if (pre_size > 0 && mr) begin
            void'(mq.pop_front());
            delivered++;
        end
        if (fl) mq.delete();
        else if (s_fire) mq.push_back(sd);
        if (fl) mcnt = 0;
        else if (CNT_EN && pre_size > 0 && !mr && mcnt < (2**CW - 1)) mcnt++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        m_ready_i = 1'b0;
        flush_i   = 1'b0;
        mq.delete();
        mcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid_o), 64'd0);
        chk("rst_s_ready", 64'(s_ready_o), 64'd1);
        chk("rst_m_data", 64'(m_data_o), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int  cyc;
        int  sent;
        logic pend;
        logic acc;
        logic rmr;
        logic [DW-1:0] pd;

        tbl[0] = '{1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11};
        tbl[1] = '{1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 32'h22};
        tbl[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h33};
        tbl[3] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h33};
        tbl[4] = '{1'b1, 32'hA,  1'b1, 1'b1, 1'b1, 32'hA};
        tbl[5] = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 32'hA};
        tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'hA};
        tbl[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hB};
        tbl[8] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'hB};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].sv, tbl[i].sd, tbl[i].mr, 1'b0);
            chk($sformatf("tbl%0d_s_ready", i), 64'(s_ready_o), 64'(tbl[i].exp_rdy));
            chk($sformatf("tbl%0d_m_valid", i), 64'(m_valid_o), 64'(tbl[i].exp_val));
            chk($sformatf("tbl%0d_m_data", i), 64'(m_data_o), 64'(tbl[i].exp_dat));
        end

        // Flush in FULL while offering 0xC: everything dropped, 0xC never appears.
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        chk("full_s_ready", 64'(s_ready_o), 64'd0);
        step(1'b1, 32'hC, 1'b0, 1'b1);
        chk("flush_m_valid", 64'(m_valid_o), 64'd0);
        chk("flush_s_ready", 64'(s_ready_o), 64'd1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_flush_m_valid", 64'(m_valid_o), 64'd0);

        // Flush in BUSY with m_fire: 0xD delivered, 0xE discarded.
        step(1'b1, 32'hD, 1'b0, 1'b0);
        step(1'b1, 32'hE, 1'b1, 1'b1);
        chk("flush_busy_m_valid", 64'(m_valid_o), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while FULL, away from the clock edge.
        step(1'b1, 32'h5A, 1'b0, 1'b0);
        step(1'b1, 32'h5B, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 64'(m_valid_o), 64'd0);
        chk("arst_s_ready", 64'(s_ready_o), 64'd1);
        chk("arst_m_data", 64'(m_data_o), 64'd0);
        mq.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stall counter: 20 backpressured cycles, then flush.
        step(1'b1, 32'h55, 1'b0, 1'b0);
        repeat (20) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall_sat", 64'(stall_cnt_o), CNT_EN ? 64'd15 : 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("stall_flush", 64'(stall_cnt_o), 64'd0);

        // Randomized 50% valid / 50% ready stream of 10000 beats.
        do_reset();
        delivered = 0;
        sent = 0;
        cyc  = 0;
        pend = 1'b0;
        pd   = '0;
        while (delivered < 10000 && cyc < 80000) begin
            if (!pend && sent < 10000 && $urandom_range(0, 1) == 1) begin
                pend = 1'b1;
                pd   = $urandom;
            end
            rmr = ($urandom_range(0, 1) == 1);
            acc = pend && (mq.size() < 2);
            step(pend, pd, rmr, 1'b0);
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
            cyc++;
        end
        chk("rand_delivered", 64'(delivered), 64'd10000);
        chk("rand_model_empty", 64'(mq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
